// File: rtl/diag_row_unpacker.sv
// Drains the per-batch anti-diagonal output SRAMs and re-emits each batch as row-major rows.
// Optional feature macro DIAG_ZERO_CHECK_EN adds a sticky diag_err flag for nonzero unused lanes.

module diag_row_unpacker #(
    parameter int unsigned ARRAY_SIZE     = 8,
    parameter int unsigned OUT_DATA_WIDTH = 16,
    parameter int unsigned BATCH_SIZE     = 3,
    parameter int unsigned MATRIX_BITS    = $clog2(2*ARRAY_SIZE-1),
    localparam int unsigned SEL_BITS      = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1,
    localparam int unsigned ROW_BITS      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
    input  logic                                 clk,
    input  logic                                 srst,
    input  logic                                 start,
    output logic                                 sram_rd_en,
    output logic [MATRIX_BITS-1:0]               sram_addr,
    output logic [SEL_BITS-1:0]                  sram_sel,
    input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata,
    output logic                                 row_valid,
    input  logic                                 row_ready,
    output logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] row_data,
    output logic [ROW_BITS-1:0]                  row_idx,
    output logic [SEL_BITS-1:0]                  row_batch,
    output logic                                 row_last,
    output logic                                 busy,
    output logic                                 done
`ifdef DIAG_ZERO_CHECK_EN
    ,
    output logic                                 diag_err
`endif
);

    localparam int unsigned N = ARRAY_SIZE;
    localparam int unsigned W = OUT_DATA_WIDTH;
    localparam logic [MATRIX_BITS-1:0] LAST_K     = MATRIX_BITS'(2*N-2);
    localparam logic [MATRIX_BITS-1:0] MID_K      = MATRIX_BITS'(N-1);
    localparam logic [ROW_BITS-1:0]    LAST_ROW   = ROW_BITS'(N-1);
    localparam logic [SEL_BITS-1:0]    LAST_BATCH = SEL_BITS'(BATCH_SIZE-1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        OUT,
        FIN
    } state_t;

    state_t                         state;
    logic [SEL_BITS-1:0]            batch;
    logic                           rd_en_q;
    logic [MATRIX_BITS-1:0]         k_q;
    logic [N-1:0][N-1:0][W-1:0]     mat;
    logic [N-1:0][W-1:0]            lane_c;
    logic [MATRIX_BITS-1:0]         off_c;
    logic [ROW_BITS-1:0]            next_row_c;
    logic [N*W-1:0]                 next_data_c;

    // Lane of C[i][k-i] is i + off_c, where off_c = N-1-min(k,N-1).
    always_comb begin
        lane_c      = sram_rdata;
        off_c       = (k_q < MID_K) ? (MID_K - k_q) : '0;
        next_row_c  = (state == OUT) ? (row_idx + ROW_BITS'(1)) : '0;
        next_data_c = mat[next_row_c];
    end

`ifdef DIAG_ZERO_CHECK_EN
    logic [MATRIX_BITS-1:0] skip_c;
    logic                   zero_err_c;

    // Lanes below skip_c = |k-(N-1)| carry no matrix element and should be zero.
    always_comb begin
        skip_c     = (k_q < MID_K) ? (MID_K - k_q) : (k_q - MID_K);
        zero_err_c = 1'b0;
        for (int unsigned l = 0; l < N; l++) begin
            if ((MATRIX_BITS'(l) < skip_c) && (lane_c[l] != '0)) begin
                zero_err_c = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state      <= IDLE;
            batch      <= '0;
            rd_en_q    <= 1'b0;
            k_q        <= '0;
            mat        <= '0;
            sram_rd_en <= 1'b0;
            sram_addr  <= '0;
            sram_sel   <= '0;
            row_valid  <= 1'b0;
            row_data   <= '0;
            row_idx    <= '0;
            row_batch  <= '0;
            row_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef DIAG_ZERO_CHECK_EN
            diag_err   <= 1'b0;
`endif
        end else begin
            // Read data returns one cycle after the strobe; track which diagonal it is.
            rd_en_q <= sram_rd_en;
            k_q     <= sram_addr;
            done    <= 1'b0;

            if (rd_en_q) begin
                for (int unsigned i = 0; i < N; i++) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        if ((i + j) == 32'(k_q)) begin
                            mat[i][j] <= lane_c[ROW_BITS'(i + 32'(off_c))];
                        end
                    end
                end
            end

`ifdef DIAG_ZERO_CHECK_EN
            if ((state == IDLE) && start) begin
                diag_err <= 1'b0;
            end else if (rd_en_q && zero_err_c) begin
                diag_err <= 1'b1;
            end
`endif

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= READ;
                        busy       <= 1'b1;
                        batch      <= '0;
                        sram_rd_en <= 1'b1;
                        sram_addr  <= '0;
                        sram_sel   <= '0;
                    end
                end

                READ: begin
                    if (sram_addr == LAST_K) begin
                        state      <= DRAIN;
                        sram_rd_en <= 1'b0;
                    end else begin
                        sram_addr <= sram_addr + MATRIX_BITS'(1);
                    end
                end

                // Row 0 never needs the final diagonal, so it can load while that word lands.
                DRAIN: begin
                    state     <= OUT;
                    row_valid <= 1'b1;
                    row_idx   <= '0;
                    row_batch <= batch;
                    row_data  <= next_data_c;
                    row_last  <= (batch == LAST_BATCH) && (LAST_ROW == ROW_BITS'(0));
                end

                OUT: begin
                    if (row_ready) begin
                        if (row_idx == LAST_ROW) begin
                            row_valid <= 1'b0;
                            row_last  <= 1'b0;
                            if (batch == LAST_BATCH) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                state      <= READ;
                                batch      <= batch + SEL_BITS'(1);
                                sram_sel   <= batch + SEL_BITS'(1);
                                sram_rd_en <= 1'b1;
                                sram_addr  <= '0;
                            end
                        end else begin
                            row_idx  <= next_row_c;
                            row_data <= next_data_c;
                            row_last <= (next_row_c == LAST_ROW) && (batch == LAST_BATCH);
                        end
                    end
                end

                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_row_unpacker.sv
// Scoreboard bench for diag_row_unpacker: SRAM model, directed runs, back-pressure and mid-read reset.

module tb_diag_row_unpacker;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 16;
    localparam int unsigned B  = 3;
    localparam int unsigned MB = 4;
    localparam int unsigned SB = 2;
    localparam int unsigned RB = 3;
    localparam int unsigned DW = N*W;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [RB-1:0] idx;
        logic [SB-1:0] batch;
        logic          last;
    } exp_row_t;

    logic          clk = 1'b0;
    logic          srst;
    logic          start;
    logic          sram_rd_en;
    logic [MB-1:0] sram_addr;
    logic [SB-1:0] sram_sel;
    logic [DW-1:0] sram_rdata = '0;
    logic          row_valid;
    logic          row_ready;
    logic [DW-1:0] row_data;
    logic [RB-1:0] row_idx;
    logic [SB-1:0] row_batch;
    logic          row_last;
    logic          busy;
    logic          done;
`ifdef DIAG_ZERO_CHECK_EN
    logic          diag_err;
`endif

    diag_row_unpacker #(
        .ARRAY_SIZE    (N),
        .OUT_DATA_WIDTH(W),
        .BATCH_SIZE    (B)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .start     (start),
        .sram_rd_en(sram_rd_en),
        .sram_addr (sram_addr),
        .sram_sel  (sram_sel),
        .sram_rdata(sram_rdata),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .row_batch (row_batch),
        .row_last  (row_last),
        .busy      (busy),
        .done      (done)
`ifdef DIAG_ZERO_CHECK_EN
        ,
        .diag_err  (diag_err)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [B][2*N-1];
    logic [W-1:0]  exp_c [B][N][N];
    exp_row_t      exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int first_valid_cyc;
    int done_cnt;
    int done_cyc;
    int last_hs_cyc;
    bit id_run      = 1'b0;

    // Output SRAM bank: one-cycle read latency.
    always @(posedge clk) begin
        if (sram_rd_en) sram_rdata <= mem[sram_sel][sram_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_identity();
        for (int b = 0; b < int'(B); b++)
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N); j++)
                    exp_c[b][i][j] = W'(256*b + 16*i + j);
    endtask

    // Diagonal layout: lane N-1-m of word k holds C[imax-m][k-imax+m].
    task automatic encode();
        logic [DW-1:0] word;
        int imax, cnt;
        for (int b = 0; b < int'(B); b++) begin
            for (int k = 0; k < int'(2*N-1); k++) begin
                word = '0;
                imax = (k < int'(N)-1) ? k : int'(N)-1;
                cnt  = int'(N) - ((k > int'(N)-1) ? k-(int'(N)-1) : (int'(N)-1)-k);
                for (int m = 0; m < cnt; m++)
                    word[(int'(N)-1-m)*int'(W) +: W] = exp_c[b][imax-m][k-imax+m];
                mem[b][k] = word;
            end
        end
    endtask

    function automatic logic [DW-1:0] pack_row(input int b, input int i);
        logic [DW-1:0] d;
        d = '0;
        for (int j = 0; j < int'(N); j++) d[j*int'(W) +: W] = exp_c[b][i][j];
        return d;
    endfunction

    task automatic push_rows();
        exp_row_t r;
        for (int b = 0; b < int'(B); b++) begin
            for (int i = 0; i < int'(N); i++) begin
                r.data  = pack_row(b, i);
                r.idx   = RB'(i);
                r.batch = SB'(b);
                r.last  = (b == int'(B)-1) && (i == int'(N)-1);
                exp_q.push_back(r);
            end
        end
    endtask

    // Monitor: pops one expected row per handshake, independent of the stimulus.
    initial begin : monitor
        exp_row_t e;
        forever begin
            @(negedge clk);
            #1;
            if (row_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (row_valid && row_ready) begin
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_row: got batch %0d idx %0d expected no row", row_batch, row_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_data", row_data, e.data);
                    chk("row_idx", DW'(row_idx), DW'(e.idx));
                    chk("row_batch", DW'(row_batch), DW'(e.batch));
                    chk("row_last", DW'(row_last), DW'(e.last));
                    if (id_run && row_batch == SB'(1) && row_idx == RB'(3))
                        chk("b1_r3_lane5", DW'(row_data[5*W +: W]), DW'(16'h0135));
                end
            end
        end
    end

    // mode 0: ready always high; 1: stall batch 0 row 2 for 5 cycles; 2: reset at batch 1 k=6.
    task automatic run(input int mode, input int exp_done_rel);
        int  t0;
        bit  seen;
        bit  stalled;
        first_valid_cyc = -1;
        done_cnt        = 0;
        done_cyc        = -1;
        last_hs_cyc     = -1;
        seen            = 1'b0;
        stalled         = 1'b0;
        push_rows();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc - 1;
        chk("first_read", DW'({sram_rd_en, sram_sel, sram_addr, busy}), DW'({1'b1, 2'd0, 4'd0, 1'b1}));
`ifdef DIAG_ZERO_CHECK_EN
        chk("diag_err_cleared_by_start", DW'(diag_err), DW'(1'b0));
`endif
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (mode == 1 && !stalled && row_valid && row_idx == RB'(2) && row_batch == SB'(0)) begin
                stalled   = 1'b1;
                row_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_data", row_data, pack_row(0, 2));
                    chk("stall_idx", DW'({row_valid, row_idx}), DW'({1'b1, 3'd2}));
                end
                row_ready = 1'b1;
            end
            if (mode == 2 && sram_rd_en && sram_sel == SB'(1) && sram_addr == MB'(6)) begin
                srst = 1'b1;
                @(negedge clk);
                chk("rst_ctrl", DW'({sram_rd_en, sram_addr, sram_sel, row_valid, row_idx,
                                     row_batch, row_last, done}), '0);
                chk("rst_data", row_data, '0);
                chk("rst_busy", DW'(busy), DW'(1'b0));
`ifdef DIAG_ZERO_CHECK_EN
                chk("rst_diag_err", DW'(diag_err), DW'(1'b0));
`endif
                srst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                return;
            end
        end
        if (!seen) begin
            chk("done_timeout", DW'(1'b0), DW'(1'b1));
        end else begin
            chk("done_cycle", DW'(cyc - t0), DW'(exp_done_rel));
            @(negedge clk);
            @(negedge clk);
            chk("first_valid_cycle", DW'(first_valid_cyc - t0), DW'(17));
            chk("done_after_last_row", DW'(done_cyc - last_hs_cyc), DW'(1));
            chk("done_pulses", DW'(done_cnt), DW'(1));
            chk("rows_left", DW'(exp_q.size()), DW'(0));
            chk("idle_busy", DW'({busy, done}), DW'(2'b00));
        end
    endtask

    initial begin : stimulus
        srst      = 1'b1;
        start     = 1'b0;
        row_ready = 1'b1;
        fill_identity();
        encode();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", DW'({sram_rd_en, sram_addr, sram_sel, row_valid, row_idx,
                               row_batch, row_last, busy, done}), '0);
        chk("reset_data", row_data, '0);
        srst = 1'b0;
        @(negedge clk);

        id_run = 1'b1;
        run(0, 73);
        id_run = 1'b0;
`ifdef DIAG_ZERO_CHECK_EN
        chk("diag_err_clean", DW'(diag_err), DW'(1'b0));
`endif

        // Hand-built words for k=0, k=7 (full) and k=14, plus a stray bit in an unused lane of k=2.
        fill_identity();
        exp_c[0][0][0] = 16'hA5A5;
        exp_c[0][7][7] = 16'h5A5A;
        for (int m = 0; m < int'(N); m++) exp_c[0][m][7-m] = W'(16'h7000 + m);
        encode();
        mem[0][0]  = 128'hA5A5_0000_0000_0000_0000_0000_0000_0000;
        mem[0][7]  = 128'h7007_7006_7005_7004_7003_7002_7001_7000;
        mem[0][14] = 128'h5A5A_0000_0000_0000_0000_0000_0000_0000;
        mem[0][2][15:0] = 16'h0001;
        run(1, 78);
`ifdef DIAG_ZERO_CHECK_EN
        chk("diag_err_set", DW'(diag_err), DW'(1'b1));
        repeat (4) @(negedge clk);
        chk("diag_err_sticky", DW'(diag_err), DW'(1'b1));
`endif

        fill_identity();
        encode();
        run(2, 0);
        run(0, 73);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/diag_row_unpacker.md
Name: diag_row_unpacker

Overview:
- Drains the TPU output SRAMs after `tpu_finish` and converts each batch's anti-diagonal result layout back to row-major matrix rows.
- Input layout: address k of a batch SRAM holds all C[i][j] with i+j == k.
- Sits downstream of the output SRAM bank. Feeds host readback / next-layer logic through a valid/ready row stream, one batch after another.

Parameters:
- ARRAY_SIZE, 8, matrix dimension N; each SRAM word holds N lanes.
- OUT_DATA_WIDTH, 16, lane width W in bits; two's complement, passed through unmodified.
- BATCH_SIZE, 3, number of output SRAMs (one per batch), read in order 0..BATCH_SIZE-1.
- MATRIX_BITS, $clog2(2*ARRAY_SIZE-1), SRAM address width.

Ports:
- clk  in  1  clock.
- srst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begin unpacking all batches.
- sram_rd_en  out  1  read strobe to the selected output SRAM.
- sram_addr  out  MATRIX_BITS  diagonal address 0..2N-2.
- sram_sel  out  max(1,$clog2(BATCH_SIZE))  batch SRAM select.
- sram_rdata  in  N*W  read data, valid the cycle after sram_rd_en.
- row_valid  out  1  row_data holds a complete row.
- row_ready  in  1  consumer accepts the row.
- row_data  out  N*W  lane j (bits j*W +: W) = C[i][j].
- row_idx  out  $clog2(N)  row index i.
- row_batch  out  max(1,$clog2(BATCH_SIZE))  batch of the current row.
- row_last  out  1  high with the final row of the final batch.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row handshake.

Behaviour:
- Reset (srst=1 at an edge):
  - State goes to IDLE and all counters clear.
  - All outputs are 0.
  - Capture matrix is cleared.
  - This applies mid-operation too; no partial done pulse is produced.
- FSM states: IDLE, READ, DRAIN, OUT, FIN.
- IDLE:
  - start=1 moves to READ with batch=0, addr=0.
  - start is ignored in all other states.
- READ:
  - sram_rd_en=1 every cycle, sram_addr = k = 0..2N-2, sram_sel = batch.
  - After k=2N-2, go to DRAIN.
- Capture:
  - Each rdata word is decoded in the cycle after its read.
  - For diagonal k: i_max = min(k,N-1), cnt = N - |k-(N-1)|.
  - Lane N-1-m holds C[i_max-m][k-(i_max-m)] for m = 0..cnt-1.
  - Lanes 0..N-1-cnt are don't-care (normally zero) and are not stored.
- DRAIN: one cycle that captures the last word (k=2N-2), sram_rd_en=0; then OUT with row=0.
- OUT:
  - row_valid=1, row_data = captured row[row], row_idx=row, row_batch=batch.
  - A handshake (row_valid && row_ready) advances row.
  - While row_ready=0, row_data/row_idx/row_batch stay stable.
  - After the handshake on row N-1:
    - if batch < BATCH_SIZE-1: batch++, go to READ, addr=0;
    - else go to FIN.
- FIN: done=1 for one cycle, then IDLE. row_last=1 only on row N-1 of batch BATCH_SIZE-1 while row_valid.
- Latency (N=8): start sampled at edge 0 gives:
  - reads in cycles 1..15;
  - DRAIN in cycle 16;
  - row_valid first high in cycle 17.
- Per-batch cost: 2N cycles plus N rows (with row_ready=1).
- Next batch: its reads start the cycle after the last row handshake; no overlap between batches.

Optional Feature:
- Macro: DIAG_ZERO_CHECK_EN.
- When defined, adds output `diag_err` (1 bit, reset 0).
  - It is set sticky when any non-stored lane (0..N-1-cnt) of a captured word is nonzero.
  - It is cleared by srst or by an accepted start.
- When not defined: no port and no check logic; behaviour is otherwise identical.

Test Plan:
- Identity decode:
  - Stimulus: N=8, each batch b filled with C[i][j] = 256*b + 16*i + j in the diagonal layout; row_ready=1.
  - Required: 24 rows in order. Batch 1 row 3 lane 5 = 0x0135. done pulses once, 1 cycle after the last row.
- Diagonal k=7 (full):
  - Stimulus: address 7 with lane m = C[m][7-m].
  - Required: row m lane 7-m correct for all m.
- Diagonals k=0 and k=14 (single element):
  - Required: lane 7 of the word maps to C[0][0] and C[7][7] respectively.
- Back-pressure:
  - Stimulus: row_ready held 0 for 5 cycles on batch 0 row 2.
  - Required: row_data/row_idx stable and no advance; total cycle count grows by exactly 5.
- Reset mid-READ:
  - Stimulus: srst at k=6 of batch 1.
  - Required: next cycle all outputs 0 and busy=0. A fresh start re-reads from batch 0, addr 0.
- DIAG_ZERO_CHECK_EN:
  - Stimulus: address 2, lane 0 = 0x0001.
  - Required: diag_err=1 and stays 1 until the next start; without the macro, results are unchanged.
